elevator_request_queue: RTL and testbench

- Upstream feeder for the ElevatorLogic core.
- Accepts passenger trips as (source floor, destination floor) pairs through a valid/ready handshake and buffers them in a FIFO.
- Presents exactly one trip at a time on the core's request_up/request_down one-hot and requested_floor inputs, and holds it stable until the core reports it served.
- Rejects malformed trips and provides occupancy status for the hall panel.

---
 rtl/elevator_pkg.sv | 37 +++
 rtl/elevator_request_queue_trip_fifo.sv | 59 +++++
 rtl/elevator_request_queue.sv | 125 ++++++++++++
 tb/tb_elevator_request_queue.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and default floor geometry for the elevator core and its request queue.
package elevator_pkg;

  // Defaults; the core and the request queue must be built with the same values.
  localparam int MAXFLOORS = 10;
  localparam int MINFLOORS = 0;
  localparam int N_FLOORS  = MAXFLOORS - MINFLOORS;
  localparam int FLOOR_W   = 4;

  typedef logic [FLOOR_W-1:0] floor_t;

  // Encoding is shared with the core's direction_o output.
  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  typedef struct packed {
    floor_t src;
    floor_t dst;
    dir_e   dir;
  } trip_t;

  // Queue presenter states.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPresent = 2'd1,
    StDrain   = 2'd2
  } state_e;

  // Travel direction of a trip that has already been checked for src != dst.
  function automatic dir_e trip_dir(floor_t src, floor_t dst);
    return (dst > src) ? DIR_UP : DIR_DOWN;
  endfunction

endpackage

// File: rtl/elevator_request_queue_trip_fifo.sv
// Synchronous FIFO of trip_t records with a synchronous active-low reset.
// Full pushes and empty pops are ignored; DEPTH must be a power of two.
module trip_fifo
  import elevator_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  trip_t                    i_data,
  input  logic                     i_pop,
  output trip_t                    o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  trip_t            r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/elevator_request_queue.sv
// Trip request queue feeding the ElevatorLogic core: validates offered trips, buffers them,
// and presents the oldest one as a one-hot hall call until the core reports it served.
module elevator_request_queue #(
  parameter int          MAXFLOORS = elevator_pkg::MAXFLOORS,
  parameter int          MINFLOORS = elevator_pkg::MINFLOORS,
  parameter int unsigned DEPTH     = 4,
  parameter int          FLOOR_W   = elevator_pkg::FLOOR_W,
  localparam int         N_FLOORS  = MAXFLOORS - MINFLOORS,
  localparam int         CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                trip_valid_i,
  output logic                trip_ready_o,
  input  logic [FLOOR_W-1:0]  trip_src_i,
  input  logic [FLOOR_W-1:0]  trip_dst_i,
  output logic                trip_reject_o,
  output logic [N_FLOORS-1:0] request_up_o,
  output logic [N_FLOORS-1:0] request_down_o,
  output logic [FLOOR_W-1:0]  requested_floor_o,
  input  logic                served_i,
  output logic [CNT_W-1:0]    pending_o,
  output logic                busy_o
);

  import elevator_pkg::*;

  state_e               r_state;
  state_e               w_state_next;
  logic                 r_reject;
  logic [FLOOR_W-1:0]   r_last_dst;

  trip_t                w_trip;
  trip_t                w_head;
  logic                 w_full;
  logic                 w_empty;
  logic [CNT_W-1:0]     w_count;
  logic                 w_trip_ok;
  logic                 w_consume;
  logic                 w_push;
  logic                 w_pop;
  int                   w_src_int;
  int                   w_dst_int;
  logic [FLOOR_W-1:0]   w_head_idx;
  logic [N_FLOORS-1:0]  w_onehot;

  // Bounds are checked in signed int so a MINFLOORS of zero needs no special casing.
  assign w_src_int = int'(trip_src_i);
  assign w_dst_int = int'(trip_dst_i);
  assign w_trip_ok = (w_src_int >= MINFLOORS) && (w_src_int < MAXFLOORS) &&
                     (w_dst_int >= MINFLOORS) && (w_dst_int < MAXFLOORS) &&
                     (trip_src_i != trip_dst_i);

  assign trip_ready_o = !w_full;
  assign w_consume    = trip_valid_i && trip_ready_o;
  assign w_push       = w_consume && w_trip_ok;
  assign w_pop        = (r_state == StPresent) && served_i;

  assign w_trip.src = trip_src_i;
  assign w_trip.dst = trip_dst_i;
  assign w_trip.dir = trip_dir(trip_src_i, trip_dst_i);

  trip_fifo #(
    .DEPTH (DEPTH)
  ) u_trip_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_push  (w_push),
    .i_data  (w_trip),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Presenter state, reject pulse and the destination held through DRAIN.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= StIdle;
      r_reject   <= 1'b0;
      r_last_dst <= '0;
    end else begin
      r_state  <= w_state_next;
      r_reject <= w_consume && !w_trip_ok;
      if (w_pop) r_last_dst <= w_head.dst;
    end
  end

  // Next state: DRAIN waits for served_i to drop so one served level pops exactly once.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (!w_empty) w_state_next = StPresent;
      StPresent: if (served_i) w_state_next = StDrain;
      StDrain:   if (!served_i) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // Stored trips are already validated, so the offset always lands inside the vector.
  assign w_head_idx = FLOOR_W'(int'(w_head.src) - MINFLOORS);
  assign w_onehot   = N_FLOORS'(1) << w_head_idx;

  // Output decode from registered state and FIFO head only.
  always_comb begin
    request_up_o      = '0;
    request_down_o    = '0;
    requested_floor_o = '0;
    unique case (r_state)
      StPresent: begin
        if (w_head.dir == DIR_UP) request_up_o = w_onehot;
        else                      request_down_o = w_onehot;
        requested_floor_o = w_head.dst;
      end
      StDrain: requested_floor_o = r_last_dst;
      default: ;
    endcase
  end

  assign trip_reject_o = r_reject;
  assign pending_o     = w_count;
  assign busy_o        = (r_state != StIdle);

endmodule

// File: tb/tb_elevator_request_queue.sv
// Directed and randomized bench for elevator_request_queue against a queue-based trip model.
module tb_elevator_request_queue;

  localparam int MAXF  = 10;
  localparam int MINF  = 0;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       trip_valid_i;
  logic       trip_ready_o;
  logic [3:0] trip_src_i;
  logic [3:0] trip_dst_i;
  logic       trip_reject_o;
  logic [9:0] request_up_o;
  logic [9:0] request_down_o;
  logic [3:0] requested_floor_o;
  logic       served_i;
  logic [2:0] pending_o;
  logic       busy_o;

  always #5 clk = ~clk;

  elevator_request_queue #(
    .MAXFLOORS (MAXF),
    .MINFLOORS (MINF),
    .DEPTH     (DEPTH),
    .FLOOR_W   (4)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .trip_valid_i      (trip_valid_i),
    .trip_ready_o      (trip_ready_o),
    .trip_src_i        (trip_src_i),
    .trip_dst_i        (trip_dst_i),
    .trip_reject_o     (trip_reject_o),
    .request_up_o      (request_up_o),
    .request_down_o    (request_down_o),
    .requested_floor_o (requested_floor_o),
    .served_i          (served_i),
    .pending_o         (pending_o),
    .busy_o            (busy_o)
  );

  // Reference model: a list of accepted trips plus the presenter phase.
  // Phase 0 = nothing shown, 1 = head shown, 2 = waiting for served to drop.
  typedef struct {
    int src;
    int dst;
  } mtrip_t;

  mtrip_t mq[$];
  int     m_phase = 0;
  int     m_last  = 0;
  bit     m_rej   = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  function automatic bit trip_valid(int s, int d);
    return (s >= MINF) && (s < MAXF) && (d >= MINF) && (d < MAXF) && (s != d);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance the model across one rising edge using the inputs sampled at that edge.
  task automatic model_edge(bit rst_n, bit v, int s, int d, bit srv);
    bit     can_take;
    int     size_before;
    mtrip_t t;
    if (!rst_n) begin
      mq.delete();
      m_phase = 0;
      m_last  = 0;
      m_rej   = 1'b0;
      return;
    end
    can_take    = (mq.size() < DEPTH);
    size_before = mq.size();
    m_rej       = 1'b0;
    case (m_phase)
      0: if (size_before > 0) m_phase = 1;
      1: if (srv) begin
        m_last = mq[0].dst;
        void'(mq.pop_front());
        m_phase = 2;
      end
      default: if (!srv) m_phase = 0;
    endcase
    if (v && can_take) begin
      if (trip_valid(s, d)) begin
        t.src = s;
        t.dst = d;
        mq.push_back(t);
      end else begin
        m_rej = 1'b1;
      end
    end
  endtask

  task automatic check_all(string tag);
    int e_up = 0;
    int e_dn = 0;
    int e_fl = 0;
    if (m_phase == 1) begin
      if (mq[0].dst > mq[0].src) e_up = 1 << (mq[0].src - MINF);
      else                       e_dn = 1 << (mq[0].src - MINF);
      e_fl = mq[0].dst;
    end else if (m_phase == 2) begin
      e_fl = m_last;
    end
    check({tag, "_ready"},   32'(trip_ready_o),      32'(mq.size() < DEPTH));
    check({tag, "_reject"},  32'(trip_reject_o),     32'(m_rej));
    check({tag, "_up"},      32'(request_up_o),      32'(e_up));
    check({tag, "_down"},    32'(request_down_o),    32'(e_dn));
    check({tag, "_floor"},   32'(requested_floor_o), 32'(e_fl));
    check({tag, "_pending"}, 32'(pending_o),         32'(mq.size()));
    check({tag, "_busy"},    32'(busy_o),            32'(m_phase != 0));
  endtask

  // Drive on the falling edge, update the model at the rising edge, check 1 ns later.
  task automatic step(bit rst_n, bit v, int s, int d, bit srv, string tag);
    @(negedge clk);
    rst_i        = rst_n;
    trip_valid_i = v;
    trip_src_i   = 4'(s);
    trip_dst_i   = 4'(d);
    served_i     = srv;
    @(posedge clk);
    model_edge(rst_n, v, int'(trip_src_i), int'(trip_dst_i), srv);
    #1;
    check_all(tag);
  endtask

  // Serve everything outstanding; bounded so a stuck DUT still reaches the summary.
  task automatic drain(string tag);
    for (int i = 0; i < 80 && (mq.size() > 0 || m_phase != 0); i++) begin
      step(1'b1, 1'b0, 0, 0, m_phase == 1, tag);
    end
  endtask

  initial begin
    rst_i        = 1'b0;
    trip_valid_i = 1'b0;
    trip_src_i   = '0;
    trip_dst_i   = '0;
    served_i     = 1'b0;

    // 1: reset, single up trip, served held for three cycles
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 0, 0, 1'b0, "t1_rst");
    step(1'b1, 1'b1, 4, 8, 1'b0, "t1_push");
    step(1'b1, 1'b0, 0, 0, 1'b0, "t1_show");
    check("t1_up_const", 32'(request_up_o), 32'h010);
    check("t1_floor_const", 32'(requested_floor_o), 32'd8);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 1'b1, "t1_served");
    step(1'b1, 1'b0, 0, 0, 1'b0, "t1_release");
    step(1'b1, 1'b0, 0, 0, 1'b0, "t1_idle");
    check("t1_pending_const", 32'(pending_o), 32'd0);

    // 2: down trip, second trip queued behind it
    step(1'b1, 1'b1, 9, 2, 1'b0, "t2_push_a");
    step(1'b1, 1'b0, 0, 0, 1'b0, "t2_show_a");
    check("t2_down_const", 32'(request_down_o), 32'h200);
    step(1'b1, 1'b1, 6, 3, 1'b0, "t2_push_b");
    check("t2_pending_const", 32'(pending_o), 32'd2);
    step(1'b1, 1'b0, 0, 0, 1'b0, "t2_hold");
    step(1'b1, 1'b0, 0, 0, 1'b1, "t2_serve_a");
    step(1'b1, 1'b0, 0, 0, 1'b0, "t2_drain");
    step(1'b1, 1'b0, 0, 0, 1'b0, "t2_show_b");
    check("t2_down_b_const", 32'(request_down_o), 32'h040);
    drain("t2_clear");

    // 3: malformed trips
    step(1'b1, 1'b1, 5, 5, 1'b0, "t3_same");
    step(1'b1, 1'b0, 0, 0, 1'b0, "t3_gap1");
    step(1'b1, 1'b1, 12, 3, 1'b0, "t3_src_hi");
    step(1'b1, 1'b0, 0, 0, 1'b0, "t3_gap2");
    step(1'b1, 1'b1, 3, 10, 1'b0, "t3_dst_hi");
    check("t3_reject_const", 32'(trip_reject_o), 32'd1);
    step(1'b1, 1'b0, 0, 0, 1'b0, "t3_gap3");

    // 4: fill the queue, fifth offer must not be consumed
    step(1'b1, 1'b1, 2, 9, 1'b0, "t4_push0");
    step(1'b1, 1'b1, 3, 6, 1'b0, "t4_push1");
    step(1'b1, 1'b1, 1, 0, 1'b0, "t4_push2");
    step(1'b1, 1'b1, 7, 8, 1'b0, "t4_push3");
    check("t4_full_const", 32'(trip_ready_o), 32'd0);
    step(1'b1, 1'b1, 5, 1, 1'b0, "t4_push4");
    check("t4_pending_const", 32'(pending_o), 32'd4);

    // 5: pop and push on the same edge while full
    step(1'b1, 1'b1, 0, 5, 1'b1, "t5_both");
    check("t5_pending_after_pop", 32'(pending_o), 32'd3);
    step(1'b1, 1'b1, 0, 5, 1'b0, "t5_retry");
    check("t5_pending_const", 32'(pending_o), 32'd4);
    drain("t5_clear");

    // 6: reset while presenting with three pending
    step(1'b1, 1'b1, 1, 4, 1'b0, "t6_push0");
    step(1'b1, 1'b1, 8, 2, 1'b0, "t6_push1");
    step(1'b1, 1'b1, 0, 9, 1'b0, "t6_push2");
    step(1'b0, 1'b0, 0, 0, 1'b0, "t6_reset");
    check("t6_pending_const", 32'(pending_o), 32'd0);
    step(1'b1, 1'b0, 0, 0, 1'b0, "t6_release");
    step(1'b1, 1'b1, 2, 9, 1'b0, "t6_push");
    step(1'b1, 1'b0, 0, 0, 1'b0, "t6_show");
    check("t6_up_const", 32'(request_up_o), 32'h004);
    drain("t6_clear");

    // Randomized traffic, mostly in-range floors, occasional reset
    for (int i = 0; i < 600; i++) begin
      bit rn;
      bit v;
      bit srv;
      int s;
      int d;
      rn  = ($urandom_range(0, 99) != 0);
      v   = ($urandom_range(0, 1) == 1);
      s   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      d   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      srv = ($urandom_range(0, 2) == 0);
      step(rn, v, s, d, srv, "rnd");
    end
    drain("rnd_clear");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
